// File: rtl/sbox_phi_sweep.sv
// sbox_phi_sweep: loads an N-bit S-box, builds one truth-table index per output bit,
// then sweeps every input through an external phi table to read the S-box back and check it.
module sbox_phi_sweep #(
  parameter int unsigned N = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [N*(1<<N)-1:0]         cfg_sbox,
  output logic [N-1:0]                phi_a,
  input  logic [(1<<(1<<N))-1:0]      phi_z,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0]                out_x,
  output logic [N-1:0]                out_y,
  output logic                        done,
  output logic                        result_ok,
  output logic                        result_perm
);

  localparam int unsigned NX = 1 << N;
  localparam int unsigned SW = N * NX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUILD,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          sbox_q, sbox_d;
  logic [N-1:0][NX-1:0]   tt_q, tt_d;
  logic [N-1:0]           x_q, x_d;
  logic [NX-1:0]          seen_q, seen_d;
  logic                   mismatch_q, mismatch_d;
  logic                   cfg_ready_q, cfg_ready_d;
  logic [N-1:0]           phi_a_q, phi_a_d;
  logic                   out_valid_q, out_valid_d;
  logic [N-1:0]           out_x_q, out_x_d;
  logic [N-1:0]           out_y_q, out_y_d;
  logic                   done_q, done_d;
  logic                   result_ok_q, result_ok_d;
  logic                   result_perm_q, result_perm_d;

  logic [N-1:0]           y_now;
  logic                   slot_free;

  // Each output bit j is the phi value of truth table tt_j at the current phi_a.
  always_comb begin
    y_now = '0;
    for (int unsigned j = 0; j < N; j++) begin
      y_now[j] = phi_z[tt_q[j]];
    end
  end

  assign slot_free = !out_valid_q || out_ready;

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    sbox_d        = sbox_q;
    tt_d          = tt_q;
    x_d           = x_q;
    seen_d        = seen_q;
    mismatch_d    = mismatch_q;
    cfg_ready_d   = cfg_ready_q;
    phi_a_d       = phi_a_q;
    out_valid_d   = out_valid_q;
    out_x_d       = out_x_q;
    out_y_d       = out_y_q;
    done_d        = 1'b0;
    result_ok_d   = result_ok_q;
    result_perm_d = result_perm_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_valid && cfg_ready_q) begin
          sbox_d        = cfg_sbox;
          result_ok_d   = 1'b0;
          result_perm_d = 1'b0;
          seen_d        = '0;
          mismatch_d    = 1'b0;
          x_d           = '0;
          phi_a_d       = '0;
          cfg_ready_d   = 1'b0;
          state_d       = S_BUILD;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_BUILD: begin
        for (int unsigned j = 0; j < N; j++) begin
          for (int unsigned k = 0; k < NX; k++) begin
            tt_d[j][k] = sbox_q[N*k + j];
          end
        end
        phi_a_d = '0;
        state_d = S_SWEEP;
      end

      S_SWEEP: begin
        if (slot_free) begin
          out_x_d       = x_q;
          out_y_d       = y_now;
          out_valid_d   = 1'b1;
          mismatch_d    = mismatch_q | (y_now != sbox_q[N*x_q +: N]);
          seen_d[y_now] = 1'b1;
          if (x_q == N'(NX - 1)) begin
            state_d = S_DRAIN;
          end else begin
            x_d     = N'(x_q + 1'b1);
            phi_a_d = N'(x_q + 1'b1);
          end
        end
      end

      S_DRAIN: begin
        // Last result still pending; verdict is published with its handshake.
        if (out_ready) begin
          out_valid_d   = 1'b0;
          done_d        = 1'b1;
          result_ok_d   = !mismatch_q;
          result_perm_d = &seen_q;
          cfg_ready_d   = 1'b1;
          state_d       = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sbox_q        <= '0;
      tt_q          <= '0;
      x_q           <= '0;
      seen_q        <= '0;
      mismatch_q    <= 1'b0;
      cfg_ready_q   <= 1'b1;
      phi_a_q       <= '0;
      out_valid_q   <= 1'b0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      done_q        <= 1'b0;
      result_ok_q   <= 1'b0;
      result_perm_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sbox_q        <= sbox_d;
      tt_q          <= tt_d;
      x_q           <= x_d;
      seen_q        <= seen_d;
      mismatch_q    <= mismatch_d;
      cfg_ready_q   <= cfg_ready_d;
      phi_a_q       <= phi_a_d;
      out_valid_q   <= out_valid_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      done_q        <= done_d;
      result_ok_q   <= result_ok_d;
      result_perm_q <= result_perm_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign phi_a       = phi_a_q;
  assign out_valid   = out_valid_q;
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign done        = done_q;
  assign result_ok   = result_ok_q;
  assign result_perm = result_perm_q;

endmodule

// File: tb/tb_sbox_phi_sweep.sv
// Bench for sbox_phi_sweep: N=3 and N=2 instances driven by a behavioural phi table,
// with a vector table plus hand-written backpressure, reset, back-to-back sequences.
module tb_sbox_phi_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // N=3 instance signals
  logic         cfg_valid;
  logic         cfg_ready;
  logic [23:0]  cfg_sbox;
  logic [2:0]   phi_a;
  logic [255:0] phi_z;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_x;
  logic [2:0]   out_y;
  logic         done;
  logic         result_ok;
  logic         result_perm;
  logic         fault_en;

  // N=2 instance signals
  logic         cfg_valid2;
  logic         cfg_ready2;
  logic [7:0]   cfg_sbox2;
  logic [1:0]   phi_a2;
  logic [15:0]  phi_z2;
  logic         out_valid2;
  logic         out_ready2;
  logic [1:0]   out_x2;
  logic [1:0]   out_y2;
  logic         done2;
  logic         result_ok2;
  logic         result_perm2;

  sbox_phi_sweep #(.N(3)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sbox(cfg_sbox),
    .phi_a(phi_a), .phi_z(phi_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .done(done), .result_ok(result_ok), .result_perm(result_perm)
  );

  sbox_phi_sweep #(.N(2)) dut2 (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2), .cfg_sbox(cfg_sbox2),
    .phi_a(phi_a2), .phi_z(phi_z2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_x(out_x2), .out_y(out_y2),
    .done(done2), .result_ok(result_ok2), .result_perm(result_perm2)
  );

  // phi table: z[k] = bit a of k; optional stuck-at-0 on entry 170
  always_comb begin
    for (int k = 0; k < 256; k++) phi_z[k] = 1'(((k >> phi_a) & 1));
    if (fault_en) phi_z[170] = 1'b0;
  end
  always_comb begin
    for (int k = 0; k < 16; k++) phi_z2[k] = 1'(((k >> phi_a2) & 1));
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  localparam logic [23:0] IDENT = 24'hFAC688;

  typedef struct packed {
    logic [23:0] sbox;
    logic        fault;
    logic [23:0] exp_y;
    logic        exp_ok;
    logic        exp_perm;
  } vec_t;

  vec_t vecs[5];

  task automatic start_cfg(input logic [23:0] sbox);
    check("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    cfg_sbox  = sbox;
    cfg_valid = 1'b1;
  endtask

  // Called on the negedge where cfg_valid was raised; returns on the negedge showing done.
  task automatic collect(input logic [23:0] exp_y, input logic exp_ok, input logic exp_perm,
                         input int stall_x, input int stall_len);
    int n_res = 0;
    int stalls = 0;
    bit got_done = 1'b0;
    logic [23:0] ey;
    logic [2:0] e;
    ey = exp_y;
    for (int i = 0; i < 60 && !got_done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        cfg_valid = 1'b0;
        check("cfg_ready_busy", 64'(cfg_ready), 64'd0);
        check("ok_cleared", 64'(result_ok), 64'd0);
        check("perm_cleared", 64'(result_perm), 64'd0);
        check("done_low_at_start", 64'(done), 64'd0);
      end
      if (done) begin
        got_done = 1'b1;
        out_ready = 1'b1;
        check("done_at", 64'(i), 64'(10 + stall_len));
        check("result_count", 64'(n_res), 64'd8);
        check("result_ok", 64'(result_ok), 64'(exp_ok));
        check("result_perm", 64'(result_perm), 64'(exp_perm));
        check("valid_low_at_done", 64'(out_valid), 64'd0);
      end else if (out_valid) begin
        if (n_res > 7) begin
          check("extra_result", 64'(n_res), 64'd7);
        end else begin
          e = ey[3*n_res +: 3];
          if (int'(out_x) == stall_x && stalls < stall_len) begin
            out_ready = 1'b0;
            stalls++;
            check("stall_x", 64'(out_x), 64'(n_res));
            check("stall_y", 64'(out_y), 64'(e));
            check("stall_phi_a", 64'(phi_a), 64'(stall_x + 1));
          end else begin
            out_ready = 1'b1;
            check("out_x", 64'(out_x), 64'(n_res));
            check("out_y", 64'(out_y), 64'(e));
            n_res++;
          end
        end
      end
    end
    check("done_seen", 64'(got_done), 64'd1);
  endtask

  task automatic check_done_pulse();
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    int n2;
    bit found;
    bit got2;

    vecs[0] = '{sbox: IDENT,      fault: 1'b0, exp_y: IDENT,      exp_ok: 1'b1, exp_perm: 1'b1};
    vecs[1] = '{sbox: 24'h000000, fault: 1'b0, exp_y: 24'h000000, exp_ok: 1'b1, exp_perm: 1'b0};
    vecs[2] = '{sbox: IDENT,      fault: 1'b1, exp_y: 24'hDA4480, exp_ok: 1'b0, exp_perm: 1'b0};
    vecs[3] = '{sbox: 24'h053977, fault: 1'b0, exp_y: 24'h053977, exp_ok: 1'b1, exp_perm: 1'b1};
    vecs[4] = '{sbox: 24'h6D2240, fault: 1'b0, exp_y: 24'h6D2240, exp_ok: 1'b1, exp_perm: 1'b0};

    rst = 1'b1;
    cfg_valid = 1'b0; cfg_sbox = '0; out_ready = 1'b1; fault_en = 1'b0;
    cfg_valid2 = 1'b0; cfg_sbox2 = '0; out_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_phi_a", 64'(phi_a), 64'd0);
    check("rst_out_x", 64'(out_x), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ok", 64'(result_ok), 64'd0);
    check("rst_perm", 64'(result_perm), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven sweeps with no backpressure
    foreach (vecs[v]) begin
      fault_en = vecs[v].fault;
      start_cfg(vecs[v].sbox);
      collect(vecs[v].exp_y, vecs[v].exp_ok, vecs[v].exp_perm, -1, 0);
      check_done_pulse();
      fault_en = 1'b0;
    end

    // Backpressure: hold out_ready low for 3 cycles while x=2 is presented
    start_cfg(IDENT);
    collect(IDENT, 1'b1, 1'b1, 2, 3);
    check_done_pulse();

    // Reset mid-sweep once phi_a has advanced to 4
    start_cfg(IDENT);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (i == 0) cfg_valid = 1'b0;
      if (out_valid && phi_a == 3'd4) found = 1'b1;
    end
    check("reach_x4", 64'(found), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("midrst_phi_a", 64'(phi_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    start_cfg(IDENT);
    collect(IDENT, 1'b1, 1'b1, -1, 0);
    check_done_pulse();

    // Back-to-back: zero S-box, then new cfg accepted in the done cycle
    start_cfg(24'h000000);
    collect(24'h000000, 1'b1, 1'b0, -1, 0);
    start_cfg(24'h053977);
    collect(24'h053977, 1'b1, 1'b1, -1, 0);
    check_done_pulse();

    // N=2 instance, identity S-box 8'hE4
    check("n2_cfg_ready", 64'(cfg_ready2), 64'd1);
    cfg_sbox2 = 8'hE4;
    cfg_valid2 = 1'b1;
    n2 = 0;
    got2 = 1'b0;
    for (int i = 0; i < 20 && !got2; i++) begin
      @(negedge clk);
      if (i == 0) cfg_valid2 = 1'b0;
      if (done2) begin
        got2 = 1'b1;
        check("n2_done_at", 64'(i), 64'd6);
        check("n2_count", 64'(n2), 64'd4);
        check("n2_ok", 64'(result_ok2), 64'd1);
        check("n2_perm", 64'(result_perm2), 64'd1);
      end else if (out_valid2) begin
        check("n2_out_x", 64'(out_x2), 64'(n2));
        check("n2_out_y", 64'(out_y2), 64'(n2));
        n2++;
      end
    end
    check("n2_done_seen", 64'(got2), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
